// File: rtl/broadcast_queue.sv
// Elastic one-to-N broadcaster: a shared ring buffer with one write pointer and one read pointer per destination.
// Optional registered slowest-destination occupancy output o_lag, enabled by defining BROADCAST_QUEUE_LAG_EN.
module broadcast_queue #(
   parameter int N     = 2,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      src_rdy,
   output logic                      src_ack,
   input  logic [DW-1:0]             src_data,
   output logic [N-1:0]              dst_rdys,
   input  logic [N-1:0]              dst_acks,
   output logic [N*DW-1:0]           dst_datas
`ifdef BROADCAST_QUEUE_LAG_EN
   ,
   output logic [$clog2(DEPTH):0]    o_lag
`endif
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   logic [AW:0]   wptr;
   logic [AW:0]   wptr_nxt;
   logic [AW:0]   rptr     [N];
   logic [AW:0]   rptr_nxt [N];
   logic [AW:0]   occ      [N];
   logic          full;
   logic [DW-1:0] mem      [DEPTH];

   // Full only depends on registered pointers, so no dst ack can combinationally reach src_ack.
   always_comb begin
      full = 1'b0;
      for (int i = 0; i < N; i++) begin
         occ[i]      = wptr - rptr[i];
         dst_rdys[i] = (occ[i] != '0);
         if (occ[i] == FULL_OCC) begin
            full = 1'b1;
         end
      end
   end

   assign src_ack  = src_rdy && !full;
   assign wptr_nxt = src_ack ? (wptr + PTR_ONE) : wptr;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         rptr_nxt[i] = (dst_rdys[i] && dst_acks[i]) ? (rptr[i] + PTR_ONE) : rptr[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wptr <= '0;
         for (int i = 0; i < N; i++) begin
            rptr[i] <= '0;
         end
      end else begin
         wptr <= wptr_nxt;
         for (int i = 0; i < N; i++) begin
            rptr[i] <= rptr_nxt[i];
         end
      end
   end

   // Payload storage is deliberately left unreset; reset only makes old entries unreachable.
   always_ff @(posedge i_clk) begin
      if (src_ack) begin
         mem[wptr[AW-1:0]] <= src_data;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_dst
      assign dst_datas[g*DW +: DW] = mem[rptr[g][AW-1:0]];
   end

`ifdef BROADCAST_QUEUE_LAG_EN
   logic [AW:0] lag_nxt;
   logic [AW:0] occ_nxt [N];

   // The max is taken over next-state pointers so the register shows post-edge occupancy.
   always_comb begin
      lag_nxt = '0;
      for (int i = 0; i < N; i++) begin
         occ_nxt[i] = wptr_nxt - rptr_nxt[i];
         if (occ_nxt[i] > lag_nxt) begin
            lag_nxt = occ_nxt[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_lag <= '0;
      end else begin
         o_lag <= lag_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_broadcast_queue.sv
// Directed self-checking bench for broadcast_queue (N=2, DW=32, DEPTH=4).
// Inputs change on the falling edge and outputs are checked 1ns later, before the next rising edge.
module tb_broadcast_queue;

   localparam int N     = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          src_rdy;
   logic          src_ack;
   logic [DW-1:0] src_data;
   logic [N-1:0]  dst_rdys;
   logic [N-1:0]  dst_acks;
   logic [N*DW-1:0] dst_datas;
`ifdef BROADCAST_QUEUE_LAG_EN
   logic [2:0]    o_lag;
`endif

   int tests_run  = 0;
   int fail_count = 0;

   broadcast_queue #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .src_rdy   (src_rdy),
      .src_ack   (src_ack),
      .src_data  (src_data),
      .dst_rdys  (dst_rdys),
      .dst_acks  (dst_acks),
      .dst_datas (dst_datas)
`ifdef BROADCAST_QUEUE_LAG_EN
      ,
      .o_lag     (o_lag)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input logic rdy, input logic [DW-1:0] data, input logic [N-1:0] acks);
      @(negedge i_clk);
      i_rst    = rst;
      src_rdy  = rdy;
      src_data = data;
      dst_acks = acks;
      #1;
   endtask

   function automatic logic [DW-1:0] dst_word(input int i);
      return dst_datas[i*DW +: DW];
   endfunction

   int ack_count;
   int sent;
   int wcnt;
   int rcnt [N];
   int cycles;
   bit done;
   logic exp_ack;
   logic [N-1:0] acks_r;
   logic rdy_r;

   initial begin
      i_rst    = 1'b0;
      src_rdy  = 1'b1;
      src_data = '0;
      dst_acks = '0;

      // Reset and idle
      apply_stimulus(1'b0, 1'b1, 32'h55, 2'b00);
      check_output("rst_rdys_during", 64'(dst_rdys), 64'h0);
      apply_stimulus(1'b1, 1'b1, 32'h55, 2'b00);
      check_output("rst_src_ack_after", 64'(src_ack), 64'h1);
      check_output("rst_rdys_after", 64'(dst_rdys), 64'h0);
`ifdef BROADCAST_QUEUE_LAG_EN
      check_output("rst_lag", 64'(o_lag), 64'h0);
`endif
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b11);
      check_output("idle_rdys_ones", 64'(dst_rdys), 64'h3);
      check_output("idle_d0", 64'(dst_word(0)), 64'h55);
      check_output("idle_d1", 64'(dst_word(1)), 64'h55);

      // Lock-step stream
      for (int k = 0; k < 16; k++) begin
         apply_stimulus(1'b1, 1'b1, DW'(32'h10 + k), 2'b11);
         check_output("ls_src_ack", 64'(src_ack), 64'h1);
         if (k == 0) begin
            check_output("ls_rdys_empty", 64'(dst_rdys), 64'h0);
         end else begin
            check_output("ls_rdys", 64'(dst_rdys), 64'h3);
            check_output("ls_d0", 64'(dst_word(0)), 64'(32'h10 + k - 1));
            check_output("ls_d1", 64'(dst_word(1)), 64'(32'h10 + k - 1));
         end
`ifdef BROADCAST_QUEUE_LAG_EN
         check_output("ls_lag_le1", 64'(o_lag <= 3'd1), 64'h1);
`endif
      end
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b11);
      check_output("ls_last_d0", 64'(dst_word(0)), 64'h1F);
      check_output("ls_last_d1", 64'(dst_word(1)), 64'h1F);

      // Slow consumer fill: dst 0 acks every cycle, dst 1 never
      ack_count = 0;
      for (int k = 0; k < 7; k++) begin
         apply_stimulus(1'b1, 1'b1, DW'(32'h10 + ((k < 4) ? k : 4)), 2'b01);
         if (src_ack) ack_count++;
         check_output("sc_src_ack", 64'(src_ack), 64'(k < 4));
         check_output("sc_rdy0", 64'(dst_rdys[0]), 64'(k >= 1 && k <= 4));
         check_output("sc_rdy1", 64'(dst_rdys[1]), 64'(k >= 1));
         if (k >= 1 && k <= 4) begin
            check_output("sc_d0", 64'(dst_word(0)), 64'(32'h10 + k - 1));
         end
         if (k >= 1) begin
            check_output("sc_d1_stable", 64'(dst_word(1)), 64'h10);
         end
      end
      check_output("sc_ack_count", 64'(ack_count), 64'd4);
`ifdef BROADCAST_QUEUE_LAG_EN
      check_output("sc_lag_full", 64'(o_lag), 64'd4);
`endif

      // Full with drain: slowest acks at edge t, source accepted in t+1
      apply_stimulus(1'b1, 1'b1, 32'h14, 2'b10);
      check_output("fd_src_ack_t", 64'(src_ack), 64'h0);
      apply_stimulus(1'b1, 1'b1, 32'h14, 2'b00);
      check_output("fd_src_ack_t1", 64'(src_ack), 64'h1);
      check_output("fd_d1_next", 64'(dst_word(1)), 64'h11);
`ifdef BROADCAST_QUEUE_LAG_EN
      check_output("fd_lag_3", 64'(o_lag), 64'd3);
`endif
      apply_stimulus(1'b1, 1'b1, 32'h15, 2'b00);
      check_output("fd_src_ack_refull", 64'(src_ack), 64'h0);
      check_output("fd_rdys", 64'(dst_rdys), 64'h3);
      check_output("fd_d0_new", 64'(dst_word(0)), 64'h14);
`ifdef BROADCAST_QUEUE_LAG_EN
      check_output("fd_lag_4", 64'(o_lag), 64'd4);
`endif

      // Wrap-around with random gaps, reference model counts pointers
      apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00);
      sent = 0;
      wcnt = 0;
      for (int i = 0; i < N; i++) rcnt[i] = 0;
      done = 1'b0;
      cycles = 0;
      while (!done && cycles < 2000) begin
         rdy_r  = (sent < 40) && ($urandom_range(0, 3) != 0);
         acks_r = N'($urandom_range(0, 3));
         apply_stimulus(1'b1, rdy_r, DW'(32'h100 + sent), acks_r);
         exp_ack = rdy_r;
         for (int i = 0; i < N; i++) begin
            if (wcnt - rcnt[i] >= DEPTH) exp_ack = 1'b0;
         end
         check_output("wr_src_ack", 64'(src_ack), 64'(exp_ack));
         for (int i = 0; i < N; i++) begin
            check_output("wr_rdy", 64'(dst_rdys[i]), 64'(wcnt > rcnt[i]));
            if (wcnt > rcnt[i]) begin
               check_output("wr_data", 64'(dst_word(i)), 64'(32'h100 + rcnt[i]));
               if (acks_r[i]) rcnt[i]++;
            end
         end
         if (exp_ack) begin
            wcnt++;
            sent++;
         end
         done = (wcnt == 40);
         for (int i = 0; i < N; i++) begin
            if (rcnt[i] != 40) done = 1'b0;
         end
         cycles++;
      end
      check_output("wr_all_delivered", 64'(done), 64'h1);

      // Mid-stream reset with three tokens queued for dst 1
      apply_stimulus(1'b1, 1'b1, 32'hA0, 2'b01);
      apply_stimulus(1'b1, 1'b1, 32'hA1, 2'b01);
      apply_stimulus(1'b1, 1'b1, 32'hA2, 2'b01);
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00);
      check_output("mr_rdy1_before", 64'(dst_rdys[1]), 64'h1);
      check_output("mr_d1_before", 64'(dst_word(1)), 64'hA0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00);
      apply_stimulus(1'b1, 1'b1, 32'hAA, 2'b00);
      check_output("mr_rdys_after", 64'(dst_rdys), 64'h0);
      check_output("mr_src_ack", 64'(src_ack), 64'h1);
`ifdef BROADCAST_QUEUE_LAG_EN
      check_output("mr_lag", 64'(o_lag), 64'h0);
`endif
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00);
      check_output("mr_rdys_new", 64'(dst_rdys), 64'h3);
      check_output("mr_d0_new", 64'(dst_word(0)), 64'hAA);
      check_output("mr_d1_new", 64'(dst_word(1)), 64'hAA);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
